// File: rtl/eth_frame_sequencer.sv
// Byte-serial Ethernet header walker: captures MACs and type/length, counts payload,
// and reports frame completion or error with one-cycle registered pulses.
module eth_frame_sequencer #(
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500,
    parameter int CNT_W       = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             control,
    input  logic [7:0]       data,
    output logic [47:0]      dst_mac,
    output logic [47:0]      src_mac,
    output logic [15:0]      type_length,
    output logic             type_length_valid,
    output logic             packet_size_valid,
    output logic [CNT_W-1:0] byte_count,
    output logic             frame_done,
    output logic             frame_error,
    output logic [1:0]       err_code
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RUNT     = 2'd1,
        ERR_LENGTH   = 2'd2,
        ERR_OVERSIZE = 2'd3
    } err_t;

    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PAYLOAD);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PAYLOAD);
    localparam logic [CNT_W-1:0] OVER_CNT = CNT_W'(MAX_PAYLOAD + 1);
    localparam logic [15:0]      MIN_LEN  = 16'(MIN_PAYLOAD);
    localparam logic [15:0]      MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [3:0]       LAST_HDR = 4'd13;

    state_t           state_q, state_d;
    logic             armed_q, armed_d;
    logic [3:0]       hcnt_q, hcnt_d;
    logic [47:0]      dst_mac_q, dst_mac_d;
    logic [47:0]      src_mac_q, src_mac_d;
    logic [15:0]      type_length_q, type_length_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic [CNT_W-1:0] expected_q, expected_d;
    logic             length_mode_q, length_mode_d;
    logic             size_seen_q, size_seen_d;
    logic             tl_valid_q, tl_valid_d;
    logic             size_valid_q, size_valid_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    err_t             err_code_q, err_code_d;

    logic [15:0]      tl_word;
    logic [CNT_W-1:0] next_count;

    assign tl_word    = {type_length_q[15:8], data};
    assign next_count = byte_count_q + CNT_W'(1);

    always_comb begin
        // NOTE: every _d gets its hold/default value first, so no path through the
        // case below leaves a signal unassigned and no latch is inferred.
        state_d       = state_q;
        armed_d       = armed_q | ~control;
        hcnt_d        = hcnt_q;
        dst_mac_d     = dst_mac_q;
        src_mac_d     = src_mac_q;
        type_length_d = type_length_q;
        byte_count_d  = byte_count_q;
        expected_d    = expected_q;
        length_mode_d = length_mode_q;
        size_seen_d   = size_seen_q;
        err_code_d    = err_code_q;
        tl_valid_d    = 1'b0;
        size_valid_d  = 1'b0;
        done_d        = 1'b0;
        error_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (armed_q && control) begin
                    dst_mac_d[47:40] = data;
                    hcnt_d           = 4'd1;
                    byte_count_d     = '0;
                    err_code_d       = ERR_NONE;
                    state_d          = HDR;
                end
            end

            HDR: begin
                if (control) begin
                    for (int i = 0; i < 6; i++) begin
                        if (hcnt_q == 4'(i))     dst_mac_d[47-8*i -: 8] = data;
                        if (hcnt_q == 4'(i + 6)) src_mac_d[47-8*i -: 8] = data;
                    end
                    if (hcnt_q == 4'd12) type_length_d[15:8] = data;
                    if (hcnt_q == LAST_HDR) begin
                        type_length_d[7:0] = data;
                        tl_valid_d         = 1'b1;
                        size_seen_d        = 1'b0;
                        state_d            = PAYLOAD;
                        // Small length fields are padded up to the minimum payload.
                        length_mode_d      = (tl_word <= MAX_LEN);
                        if (tl_word <= MAX_LEN && tl_word > MIN_LEN)
                            expected_d = CNT_W'(tl_word);
                        else
                            expected_d = MIN_CNT;
                    end
                    hcnt_d = hcnt_q + 4'd1;
                end else begin
                    err_code_d = ERR_RUNT;
                    error_d    = 1'b1;
                    state_d    = IDLE;
                end
            end

            PAYLOAD: begin
                if (control) begin
                    if (byte_count_q >= MAX_CNT) begin
                        byte_count_d = OVER_CNT;
                        err_code_d   = ERR_OVERSIZE;
                        error_d      = 1'b1;
                        state_d      = DRAIN;
                    end else begin
                        byte_count_d = next_count;
                        if (next_count == expected_q && !size_seen_q) begin
                            size_valid_d = 1'b1;
                            size_seen_d  = 1'b1;
                        end
                    end
                end else begin
                    // Runt is checked first so it wins over a length mismatch.
                    if (byte_count_q < MIN_CNT) begin
                        err_code_d = ERR_RUNT;
                        error_d    = 1'b1;
                    end else if (length_mode_q && byte_count_q != expected_q) begin
                        err_code_d = ERR_LENGTH;
                        error_d    = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end

            DRAIN: begin
                if (!control) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous; it clears armed so a frame already in flight
    // when reset drops is skipped until the line has been seen idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            armed_q       <= 1'b0;
            hcnt_q        <= '0;
            dst_mac_q     <= '0;
            src_mac_q     <= '0;
            type_length_q <= '0;
            byte_count_q  <= '0;
            expected_q    <= '0;
            length_mode_q <= 1'b0;
            size_seen_q   <= 1'b0;
            tl_valid_q    <= 1'b0;
            size_valid_q  <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            hcnt_q        <= hcnt_d;
            dst_mac_q     <= dst_mac_d;
            src_mac_q     <= src_mac_d;
            type_length_q <= type_length_d;
            byte_count_q  <= byte_count_d;
            expected_q    <= expected_d;
            length_mode_q <= length_mode_d;
            size_seen_q   <= size_seen_d;
            tl_valid_q    <= tl_valid_d;
            size_valid_q  <= size_valid_d;
            done_q        <= done_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
        end
    end

    assign dst_mac           = dst_mac_q;
    assign src_mac           = src_mac_q;
    assign type_length       = type_length_q;
    assign type_length_valid = tl_valid_q;
    assign packet_size_valid = size_valid_q;
    assign byte_count        = byte_count_q;
    assign frame_done        = done_q;
    assign frame_error       = error_q;
    assign err_code          = err_code_q;

endmodule
